// File: rtl/cdc_pkg.sv
// Shared defaults for the clock-domain-crossing FIFO blocks.
// The reader and the async FIFO both take their payload and beat widths from here.
package cdc_pkg;

   localparam int unsigned CDC_DBITS_DEFAULT = 32;
   localparam int unsigned CDC_OBITS_DEFAULT = 8;

endpackage

// File: rtl/cdc_afifo_reader.sv
// Read-side adapter for an async FIFO: pops words into a 2-entry buffer and
// serialises each word into dbits/obits beats, LSB slice first, with valid/ready.
module cdc_afifo_reader
   import cdc_pkg::*;
#(
   parameter int unsigned dbits = CDC_DBITS_DEFAULT,
   parameter int unsigned obits = CDC_OBITS_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_rempty,
   output logic             o_rd,
   input  logic [dbits-1:0] i_rdata,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [obits-1:0] o_data,
   output logic             o_last
);

   localparam int unsigned RATIO = dbits / obits;
   localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

   typedef struct packed {
      logic [1:0]    count;
      logic          wr_ptr;
      logic          rd_ptr;
      logic [BW-1:0] beat;
   } ctrl_t;

   localparam ctrl_t CTRL_RST = '0;

   ctrl_t                       r_ctrl;
   ctrl_t                       w_ctrl_d;
   logic [RATIO-1:0][obits-1:0] r_buf [2];
   logic                        w_push;
   logic                        w_fire;
   logic                        w_release;

   // Gating with reset keeps the FIFO from being popped while words are being discarded.
   assign o_rd      = ~i_rempty & (r_ctrl.count != 2'd2) & i_nrst;
   assign w_push    = o_rd;
   assign o_valid   = (r_ctrl.count != 2'd0);
   assign o_last    = (r_ctrl.beat == LAST_BEAT);
   assign o_data    = r_buf[r_ctrl.rd_ptr][r_ctrl.beat];
   assign w_fire    = o_valid & i_ready;
   assign w_release = w_fire & o_last;

   always_comb begin
      w_ctrl_d = r_ctrl;
      if (w_fire) begin
         if (o_last) begin
            w_ctrl_d.beat   = '0;
            w_ctrl_d.rd_ptr = ~r_ctrl.rd_ptr;
         end else begin
            w_ctrl_d.beat = r_ctrl.beat + BW'(1);
         end
      end
      if (w_push) begin
         w_ctrl_d.wr_ptr = ~r_ctrl.wr_ptr;
      end
      unique case ({w_push, w_release})
         2'b10:   w_ctrl_d.count = r_ctrl.count + 2'd1;
         2'b01:   w_ctrl_d.count = r_ctrl.count - 2'd1;
         default: w_ctrl_d.count = r_ctrl.count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_ctrl <= CTRL_RST;
      end else begin
         r_ctrl <= w_ctrl_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by r_ctrl.count alone.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_buf[r_ctrl.wr_ptr] <= i_rdata;
      end
   end

endmodule

// File: tb/tb_cdc_afifo_reader.sv
// Bench for cdc_afifo_reader: a queue-based model of the FIFO, the held words and
// the beat position predicts every output; a second instance covers the 1:1 width case.
module tb_cdc_afifo_reader;

   logic        clk = 1'b0;
   logic        nrst;
   logic        rempty;
   logic [31:0] rdata;
   logic        ready;
   logic        o_rd;
   logic        o_valid;
   logic [7:0]  o_data;
   logic        o_last;

   logic        rempty2;
   logic [31:0] rdata2;
   logic        ready2;
   logic        o_rd2;
   logic        o_valid2;
   logic [31:0] o_data2;
   logic        o_last2;

   int          n_vec = 0;
   int          n_err = 0;

   logic [31:0] fifo [$];
   logic [31:0] held [$];
   logic [31:0] fifo2 [$];
   int          beat = 0;
   int          beats_out = 0;
   int          obs_rd = 0;

   always #5 clk = ~clk;

   cdc_afifo_reader #(.dbits(32), .obits(8)) u_dut (
      .i_clk    (clk),
      .i_nrst   (nrst),
      .i_rempty (rempty),
      .o_rd     (o_rd),
      .i_rdata  (rdata),
      .o_valid  (o_valid),
      .i_ready  (ready),
      .o_data   (o_data),
      .o_last   (o_last)
   );

   cdc_afifo_reader #(.dbits(32), .obits(32)) u_dut_r1 (
      .i_clk    (clk),
      .i_nrst   (nrst),
      .i_rempty (rempty2),
      .o_rd     (o_rd2),
      .i_rdata  (rdata2),
      .o_valid  (o_valid2),
      .i_ready  (ready2),
      .o_data   (o_data2),
      .o_last   (o_last2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the main instance: drive at negedge, check, then advance the model.
   task automatic cycle(input logic rdy, input logic hide);
      logic exp_rd;
      @(negedge clk);
      ready  = rdy;
      rempty = hide | (fifo.size() == 0);
      rdata  = rempty ? $urandom : fifo[0];
      #1;
      exp_rd = nrst & ~rempty & (held.size() < 2);
      check("o_rd", {31'd0, o_rd}, {31'd0, exp_rd});
      check("o_valid", {31'd0, o_valid}, {31'd0, held.size() != 0});
      obs_rd += int'(o_rd);
      if (held.size() != 0) begin
         check("o_data", {24'd0, o_data}, (held[0] >> (8 * beat)) & 32'hff);
         check("o_last", {31'd0, o_last}, {31'd0, beat == 3});
         if (ready) begin
            beats_out++;
            if (beat == 3) begin
               void'(held.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
      end else if (!nrst) begin
         check("rst_last", {31'd0, o_last}, 32'd0);
      end
      if (exp_rd) held.push_back(fifo.pop_front());
   endtask

   initial begin
      int  bo;
      int  first;
      int  last;
      int  nb;
      bit  seen;

      nrst    = 1'b0;
      rempty  = 1'b1;
      rdata   = '0;
      ready   = 1'b0;
      rempty2 = 1'b1;
      rdata2  = '0;
      ready2  = 1'b1;

      // Reset state.
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      nrst = 1'b1;

      // Single word.
      obs_rd = 0;
      bo = beats_out;
      fifo.push_back(32'h44332211);
      for (int c = 0; c < 7; c++) cycle(1'b1, 1'b0);
      check("sw_rd_count", obs_rd, 1);
      check("sw_beats", beats_out - bo, 4);
      check("sw_idle", {31'd0, o_valid}, 32'd0);

      // Backpressure with three words queued.
      obs_rd = 0;
      fifo.push_back(32'h44332211);
      fifo.push_back(32'h88776655);
      fifo.push_back(32'hccbbaa99);
      for (int c = 0; c < 10; c++) begin
         cycle(1'b0, 1'b0);
         if (o_valid) check("bp_hold", {24'd0, o_data}, 32'h11);
      end
      check("bp_rd_count", obs_rd, 2);
      bo = beats_out;
      for (int c = 0; c < 16; c++) cycle(1'b1, 1'b0);
      check("bp_beats", beats_out - bo, 12);

      // Streaming on the 1:1 instance.
      rempty = 1'b1;
      for (int i = 0; i < 16; i++) fifo2.push_back(i);
      first = -1;
      last  = -1;
      nb    = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         rempty2 = (fifo2.size() == 0);
         rdata2  = rempty2 ? $urandom : fifo2[0];
         #1;
         check("r1_rd", {31'd0, o_rd2}, {31'd0, ~rempty2});
         if (o_valid2) begin
            check("r1_data", o_data2, nb);
            check("r1_last", {31'd0, o_last2}, 32'd1);
            if (first < 0) first = c;
            last = c;
            nb++;
         end
         if (!rempty2) void'(fifo2.pop_front());
      end
      check("r1_beats", nb, 16);
      check("r1_span", last - first, 15);

      // Random ready and empty over 1000 words.
      for (int i = 0; i < 1000; i++) fifo.push_back($urandom);
      bo = beats_out;
      for (int c = 0; c < 20000 && (fifo.size() != 0 || held.size() != 0); c++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      check("rnd_drain", fifo.size() + held.size(), 0);
      check("rnd_beats", beats_out - bo, 4000);

      // Reset in the middle of a word.
      fifo.push_back(32'h44332211);
      fifo.push_back(32'h88776655);
      fifo.push_back(32'h0c0b0a09);
      for (int c = 0; c < 20 && !(held.size() != 0 && beat == 2 && held[0] == 32'h44332211);
           c++) begin
         cycle(1'b1, 1'b0);
      end
      @(posedge clk);
      #2;
      nrst = 1'b0;
      held.delete();
      beat = 0;
      #1;
      check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      check("mid_rst_rd", {31'd0, o_rd}, 32'd0);
      check("mid_rst_last", {31'd0, o_last}, 32'd0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      rempty = 1'b1;
      nrst   = 1'b1;
      seen   = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b1, 1'b0);
         if (o_valid && !seen) begin
            check("post_rst_first", {24'd0, o_data}, 32'h09);
            seen = 1'b1;
         end
      end
      check("post_rst_seen", {31'd0, seen}, 32'd1);
      check("post_rst_drain", fifo.size() + held.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cdc_afifo_reader.md
CDC_AFIFO_READER -- requirements
Module: cdc_afifo_reader

Interface
REQ-001 SHALL have parameter dbits, default 32: width of the FIFO payload word read from the async FIFO.
REQ-002 SHALL have parameter obits, default 8: width of an output beat; dbits SHALL be an integer multiple of obits, and RATIO = dbits/obits.
REQ-003 SHALL have port i_clk, input, 1: read-domain clock; this is the only clock.
REQ-004 SHALL have port i_nrst, input, 1: reset, asynchronous, active LOW.
REQ-005 SHALL have port i_rempty, input, 1: async FIFO empty flag, rclk domain.
REQ-006 SHALL have port o_rd, output, 1: async FIFO read strobe; pops the head word at the next i_clk edge.
REQ-007 SHALL have port i_rdata, input, dbits: async FIFO head word, valid whenever i_rempty=0.
REQ-008 SHALL have port o_valid, output, 1: output beat valid.
REQ-009 SHALL have port i_ready, input, 1: sink accepts the beat.
REQ-010 SHALL have port o_data, output, obits: output beat.
REQ-011 SHALL have port o_last, output, 1: the current beat is the last beat of its word.

Function
REQ-012 SHALL hold a 2-entry word buffer with write pointer, read pointer (1 bit each), occupancy count (0..2) and beat counter (0..RATIO-1).
REQ-013 Occupancy states: EMPTY (0), ONE (1), FULL (2).
- push = o_rd; release = o_valid & i_ready & o_last.
- push only: count+1. Release only: count-1. Both: count unchanged.
REQ-014 o_rd SHALL be combinational: (i_rempty=0) & (count<2) & (i_nrst=1).
REQ-015 On push, i_rdata SHALL be captured into buf[wr_ptr] in the same cycle o_rd is high, and wr_ptr SHALL toggle.
REQ-016 o_valid SHALL be (count!=0).
REQ-017 o_data SHALL be buf[rd_ptr][beat*obits +: obits], LSB slice first.
REQ-018 o_last SHALL be (beat==RATIO-1).
REQ-019 On o_valid & i_ready:
- beat<RATIO-1: beat SHALL increment.
- otherwise: beat SHALL return to 0, rd_ptr SHALL toggle, and the word SHALL be released.
REQ-020 While o_valid=1 and i_ready=0, o_data, o_last and beat SHALL remain stable.
REQ-021 Latency: a word at the FIFO head with i_rempty=0 in cycle N and count<2 SHALL appear on o_valid/o_data in cycle N+1.
REQ-022 With i_ready held 1 and the FIFO never empty, output SHALL sustain one beat per cycle with no bubble, including RATIO=1.
REQ-023 In FULL, o_rd SHALL be 0 even if a release occurs in the same cycle; the push happens the next cycle, and no data SHALL be lost or duplicated.
REQ-024 i_rdata SHALL be ignored when i_rempty=1.
REQ-025 Both pointers SHALL wrap 1->0.

Reset
REQ-026 While i_nrst=0:
- count=0, beat=0, wr_ptr=0, rd_ptr=0.
- o_valid=0, o_last=0 (for RATIO>1), o_rd=0.
- o_data is don't-care.
REQ-027 Reset asserted mid-word SHALL discard buffered words and partial beats, and SHALL NOT pop the FIFO.
REQ-028 Buffer data registers SHALL NOT be reset and SHALL be held in a separate non-reset register process.

Structure
REQ-029 A shared package cdc_pkg SHALL hold the default widths (CDC_DBITS_DEFAULT=32, CDC_OBITS_DEFAULT=8).
REQ-030 The control register struct and its reset constant SHALL be local to the module.
REQ-031 The module SHALL have no sub-module; it connects directly to the read port of cdc_afifo at integration level.
REQ-032 RTL SHALL use the two-process style: combinational next-state, plus an async-reset register process and a separate data register process.

Verification (dbits=32, obits=8 unless stated)
REQ-033 Single word: FIFO holds 0x44332211 with i_ready=1 -> o_rd high for 1 cycle; beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles; o_last only on 0x44; then o_valid=0.
REQ-034 Backpressure: 3 words queued, i_ready=0 for 10 cycles:
- o_rd asserts exactly twice, then stays 0 (FULL).
- o_data holds 0x11 throughout.
- Releasing i_ready delivers 12 beats in order.
REQ-035 Streaming, RATIO=1 (obits=32): 16 words 0..15, i_ready=1 -> 16 consecutive valid beats 0..15, no bubble after the first.
REQ-036 Random i_ready (50%) with random i_rempty over 1000 words -> scoreboard order intact; o_rd never high while i_rempty=1 or count=2.
REQ-037 Reset during beat 2 of a word -> o_valid=0 and o_rd=0 immediately. After release, the next FIFO word is output from beat 0; the discarded word does not reappear.
